instr_exec_unit: RTL and testbench



---
 rtl/instr_exec_unit_if.sv | 35 +++
 rtl/instr_exec_unit.sv | 210 +++++++++++++++++++++
 tb/tb_instr_exec_unit.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_exec_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_exec_unit_if
//  Description : Start/range request, instruction-register read port and
//                valid/ready result port of instr_exec_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_exec_unit_if #(
    parameter int ADDR_W = 5
);
    logic                     start;
    logic [ADDR_W-1:0]        first_ptr;
    logic [ADDR_W:0]          count;
    logic [ADDR_W-1:0]        read_pointer;
    logic [67:0]              instruction_word;
    logic                     res_valid;
    logic                     res_ready;
    logic signed [63:0]       result;
    logic [ADDR_W-1:0]        res_addr;
    logic [3:0]               res_opc;
    logic                     res_err;
    logic                     busy;
    logic                     done;

    modport master (
        output start, first_ptr, count, instruction_word, res_ready,
        input  read_pointer, res_valid, result, res_addr, res_opc, res_err, busy, done
    );

    modport slave (
        input  start, first_ptr, count, instruction_word, res_ready,
        output read_pointer, res_valid, result, res_addr, res_opc, res_err, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/instr_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_exec_unit
//  Description : Walks a range of instruction-register locations, executes each
//                {opc, op_a, op_b} and returns a 64-bit signed result.
//                Optional macro EXEC_FAST_DIV_EN: single-cycle DIV/MOD.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_exec_unit #(
    parameter int ADDR_W   = 5,
    parameter int DIV_ITER = 32
) (
    input  logic             clk,
    input  logic             reset,
    instr_exec_unit_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_DIVD  = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    localparam logic [3:0] OPC_ZERO  = 4'd0;
    localparam logic [3:0] OPC_PASSA = 4'd1;
    localparam logic [3:0] OPC_PASSB = 4'd2;
    localparam logic [3:0] OPC_ADD   = 4'd3;
    localparam logic [3:0] OPC_SUB   = 4'd4;
    localparam logic [3:0] OPC_MULT  = 4'd5;
    localparam logic [3:0] OPC_DIV   = 4'd6;
    localparam logic [3:0] OPC_MOD   = 4'd7;

    logic [2:0]          state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     remaining_q, remaining_d;
    logic [67:0]         instr_q, instr_d;
    logic signed [63:0]  result_q, result_d;
    logic                err_q, err_d;
    logic                done_q, done_d;

    logic [3:0]          opc;
    logic signed [63:0]  a64, b64;
    logic                b_zero;
    logic signed [63:0]  exec_res;
    logic                exec_err;

    assign opc    = instr_q[67:64];
    assign a64    = {{32{instr_q[63]}}, instr_q[63:32]};
    assign b64    = {32'd0, instr_q[31:0]};
    assign b_zero = (instr_q[31:0] == 32'd0);

    always_comb begin
        exec_res = '0;
        exec_err = 1'b0;
        case (opc)
            OPC_ZERO:  exec_res = '0;
            OPC_PASSA: exec_res = a64;
            OPC_PASSB: exec_res = b64;
            OPC_ADD:   exec_res = a64 + b64;
            OPC_SUB:   exec_res = a64 - b64;
            OPC_MULT:  exec_res = a64 * b64;
            OPC_DIV, OPC_MOD: begin
                if (b_zero) begin
                    exec_err = 1'b1;
`ifdef EXEC_FAST_DIV_EN
                end else if (opc == OPC_DIV) begin
                    exec_res = a64 / b64;
                end else begin
                    exec_res = a64 % b64;
`endif
                end
            end
            default:   exec_err = 1'b1;
        endcase
    end

`ifndef EXEC_FAST_DIV_EN
    localparam int CNT_W = $clog2(DIV_ITER + 1);

    logic [31:0]      quo_q, quo_d, rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      a_mag;
    logic [32:0]      rem_sh, rem_sub;
    logic             fits;
    logic [31:0]      quo_nx, rem_nx;
    logic [63:0]      quo_ext, rem_ext;

    // Restoring division on magnitudes; signs are reapplied when the last bit lands.
    assign a_mag   = instr_q[63] ? (~instr_q[63:32] + 32'd1) : instr_q[63:32];
    assign rem_sh  = {rem_q, quo_q[31]};
    assign rem_sub = rem_sh - {1'b0, instr_q[31:0]};
    assign fits    = (rem_sh >= {1'b0, instr_q[31:0]});
    assign rem_nx  = fits ? rem_sub[31:0] : rem_sh[31:0];
    assign quo_nx  = {quo_q[30:0], fits};
    assign quo_ext = {32'd0, quo_nx};
    assign rem_ext = {32'd0, rem_nx};
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        instr_d     = instr_q;
        result_d    = result_q;
        err_d       = err_q;
        done_d      = 1'b0;
`ifndef EXEC_FAST_DIV_EN
        quo_d       = quo_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.count != '0) begin
                        state_d     = S_FETCH;
                        ptr_d       = bus.first_ptr;
                        remaining_d = bus.count;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                instr_d = bus.instruction_word;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                result_d = exec_res;
                err_d    = exec_err;
                state_d  = S_OUT;
`ifndef EXEC_FAST_DIV_EN
                if ((opc == OPC_DIV || opc == OPC_MOD) && !b_zero) begin
                    quo_d   = a_mag;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = S_DIVD;
                end
`endif
            end
`ifndef EXEC_FAST_DIV_EN
            S_DIVD: begin
                quo_d = quo_nx;
                rem_d = rem_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DIV_ITER - 1)) begin
                    if (opc == OPC_DIV)
                        result_d = instr_q[63] ? -quo_ext : quo_ext;
                    else
                        result_d = instr_q[63] ? -rem_ext : rem_ext;
                    err_d   = 1'b0;
                    state_d = S_OUT;
                end
            end
`endif
            S_OUT: begin
                if (bus.res_ready) begin
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == (ADDR_W + 1)'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            instr_q     <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
`ifndef EXEC_FAST_DIV_EN
            quo_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            instr_q     <= instr_d;
            result_q    <= result_d;
            err_q       <= err_d;
            done_q      <= done_d;
`ifndef EXEC_FAST_DIV_EN
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign bus.read_pointer = ptr_q;
    assign bus.res_valid    = (state_q == S_OUT);
    assign bus.result       = result_q;
    assign bus.res_addr     = ptr_q;
    assign bus.res_opc      = instr_q[67:64];
    assign bus.res_err      = err_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = done_q;
endmodule
`default_nettype wire

// File: tb/tb_instr_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_exec_unit
//  Description : Directed and randomized checks of instr_exec_unit against a
//                behavioural arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_exec_unit;
    localparam int ADDR_W   = 5;
    localparam int DIV_ITER = 32;
`ifdef EXEC_FAST_DIV_EN
    localparam int DIV_EXTRA = 0;
`else
    localparam int DIV_EXTRA = DIV_ITER;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_exec_unit_if #(.ADDR_W(ADDR_W)) bus ();

    instr_exec_unit #(.ADDR_W(ADDR_W), .DIV_ITER(DIV_ITER)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [67:0] mem [32];
    assign bus.instruction_word = mem[bus.read_pointer];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [67:0] mk(input logic [3:0] opc, input int a, input int unsigned b);
        return {opc, 32'(a), 32'(b)};
    endfunction

    // Arithmetic straight from the opcode table, on 64-bit integers.
    function automatic void ref_exec(input logic [67:0] w, output logic [63:0] r, output logic e);
        longint a, b;
        a = longint'($signed(w[63:32]));
        b = longint'({32'd0, w[31:0]});
        r = '0;
        e = 1'b0;
        case (w[67:64])
            4'd0: r = '0;
            4'd1: r = a;
            4'd2: r = b;
            4'd3: r = a + b;
            4'd4: r = a - b;
            4'd5: r = a * b;
            4'd6: if (b == 0) e = 1'b1; else r = a / b;
            4'd7: if (b == 0) e = 1'b1; else r = a % b;
            default: e = 1'b1;
        endcase
    endfunction

    function automatic int exp_lat(input logic [67:0] w);
        if ((w[67:64] == 4'd6 || w[67:64] == 4'd7) && w[31:0] != 32'd0)
            return 3 + DIV_EXTRA;
        return 3;
    endfunction

    task automatic check_reset_outputs;
        chk("rst_valid",  64'(bus.res_valid), 64'd0);
        chk("rst_result", bus.result, 64'd0);
        chk("rst_addr",   64'(bus.res_addr), 64'd0);
        chk("rst_opc",    64'(bus.res_opc), 64'd0);
        chk("rst_err",    64'(bus.res_err), 64'd0);
        chk("rst_busy",   64'(bus.busy), 64'd0);
        chk("rst_done",   64'(bus.done), 64'd0);
        chk("rst_rdptr",  64'(bus.read_pointer), 64'd0);
    endtask

    // stall < 0: random 0..5 back-pressure cycles per result; else fixed count.
    task automatic run_batch(input int first, input int cnt, input int stall);
        int          lat;
        int          loc;
        int          k;
        logic [67:0] w;
        logic [63:0] er;
        logic        ee;
        bus.first_ptr = 5'(first);
        bus.count     = 6'(cnt);
        bus.start     = 1'b1;
        tick;
        bus.start     = 1'b0;
        lat = 1;
        if (cnt == 0) begin
            chk("cnt0_done",  64'(bus.done), 64'd1);
            chk("cnt0_valid", 64'(bus.res_valid), 64'd0);
            tick;
            chk("cnt0_done_clr", 64'(bus.done), 64'd0);
            chk("cnt0_valid2",   64'(bus.res_valid), 64'd0);
            return;
        end
        for (int i = 0; i < cnt; i++) begin
            loc = (first + i) % 32;
            w   = mem[loc];
            ref_exec(w, er, ee);
            chk("rdptr", 64'(bus.read_pointer), 64'(loc));
            while (!bus.res_valid && lat < 100) begin
                tick;
                lat++;
            end
            chk("latency", 64'(lat), 64'(exp_lat(w)));
            k = (stall < 0) ? int'($urandom_range(0, 5)) : stall;
            bus.res_ready = 1'b0;
            for (int j = 0; j < k; j++) begin
                if (j == 0) begin
                    bus.start     = 1'b1;
                    bus.first_ptr = 5'($urandom);
                    bus.count     = 6'($urandom_range(1, 32));
                end
                tick;
                bus.start = 1'b0;
                chk("stall_valid",  64'(bus.res_valid), 64'd1);
                chk("stall_result", bus.result, er);
                chk("stall_addr",   64'(bus.res_addr), 64'(loc));
            end
            bus.res_ready = 1'b1;
            chk("result", bus.result, er);
            chk("addr",   64'(bus.res_addr), 64'(loc));
            chk("opc",    64'(bus.res_opc), 64'(w[67:64]));
            chk("err",    64'(bus.res_err), 64'(ee));
            tick;
            bus.res_ready = 1'b0;
            lat = 1;
            if (i == cnt - 1) begin
                chk("done",      64'(bus.done), 64'd1);
                chk("busy_end",  64'(bus.busy), 64'd0);
                tick;
                chk("done_clr",  64'(bus.done), 64'd0);
                chk("busy_idle", 64'(bus.busy), 64'd0);
            end else begin
                chk("done_mid",  64'(bus.done), 64'd0);
                chk("busy_mid",  64'(bus.busy), 64'd1);
            end
        end
    endtask

    initial begin
        int         wait_cyc;
        logic [3:0] ropc;
        int         ra;
        int unsigned rb;

        for (int i = 0; i < 32; i++) mem[i] = '0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.first_ptr = '0;
        bus.count     = '0;
        bus.res_ready = 1'b0;
        tick;
        tick;
        check_reset_outputs();
        reset = 1'b0;
        tick;

        // Reset held two cycles while a result is waiting in OUT.
        mem[3] = mk(4'd5, -7, 9);
        bus.first_ptr = 5'd3;
        bus.count     = 6'd2;
        bus.start     = 1'b1;
        tick;
        bus.start = 1'b0;
        wait_cyc  = 0;
        while (!bus.res_valid && wait_cyc < 100) begin
            tick;
            wait_cyc++;
        end
        chk("pre_reset_valid", 64'(bus.res_valid), 64'd1);
        reset = 1'b1;
        tick;
        tick;
        check_reset_outputs();
        reset = 1'b0;
        tick;
        check_reset_outputs();

        // ADD, single location.
        mem[0] = mk(4'd3, -5, 7);
        run_batch(0, 1, 0);

        // SUB / MULT / PASSB sequence.
        mem[0] = mk(4'd4, 3, 10);
        mem[1] = mk(4'd5, -4, 6);
        mem[2] = mk(4'd2, 0, 15);
        run_batch(0, 3, 0);

        // DIV / MOD / divide by zero.
        mem[0] = mk(4'd6, -15, 4);
        mem[1] = mk(4'd7, -15, 4);
        mem[2] = mk(4'd6, 9, 0);
        run_batch(0, 3, 0);

        // Divider corner operands and an illegal opcode.
        mem[10] = mk(4'd6, 32'h8000_0000, 1);
        mem[11] = mk(4'd7, 32'h7fff_ffff, 32'hffff_ffff);
        mem[12] = mk(4'd6, 32'h8000_0000, 32'hffff_ffff);
        mem[13] = mk(4'd7, 100, 0);
        mem[14] = mk(4'd11, 5, 5);
        run_batch(10, 5, 0);

        // Back-pressure with an ignored start pulse.
        mem[5] = mk(4'd1, -123456, 3);
        mem[6] = mk(4'd3, 32'h7fff_ffff, 32'hffff_ffff);
        run_batch(5, 2, 5);

        // Pointer wrap and empty request.
        mem[31] = mk(4'd2, 1, 31);
        mem[0]  = mk(4'd4, 0, 32'hffff_ffff);
        mem[1]  = mk(4'd0, 77, 88);
        mem[30] = mk(4'd5, 32'h8000_0000, 32'hffff_ffff);
        run_batch(31, 2, 0);
        run_batch(30, 4, 0);
        run_batch(7, 0, 0);

        // Randomized contents and ranges.
        for (int i = 0; i < 32; i++) begin
            ropc = ($urandom % 4 == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            ra   = ($urandom % 2 == 0) ? int'($urandom) : int'($urandom_range(0, 200)) - 100;
            case ($urandom % 6)
                0:       rb = 0;
                1, 2:    rb = $urandom;
                default: rb = $urandom_range(1, 100);
            endcase
            mem[i] = mk(ropc, ra, rb);
        end
        for (int n = 0; n < 10; n++) begin
            run_batch(int'($urandom_range(0, 31)), int'($urandom_range(1, 6)),
                      ($urandom % 2 == 0) ? -1 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
